mc_control_unit: RTL

Multicycle control FSM for the 16-bit datapath. It sequences fetch, decode, execute, memory and writeback by driving the datapath's mux selects, ALU op and write strobes from IR[15:12]. Memory accesses use a ready handshake, and a timeout guards each access. Status outputs (state, halted, error flags, retired-instruction count) are exposed for bench monitoring.

---
 rtl/mc_control_unit.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle control FSM for the 16-bit datapath.
// Sequences fetch / decode / execute / memory / writeback from IR[15:12],
// drives the datapath mux selects, ALU op and write strobes, and guards
// every memory access with a bounded wait.
//
// Handshake: in FETCH, MEM_RD and MEM_WR the request (mem_rd/mem_wr) is held
// for as long as the FSM stays in that state. The access completes on a
// cycle where mem_ready=1, and the FSM leaves the state on that clock edge.
// If mem_ready stays low for MEM_TIMEOUT cycles, the FSM gives up and goes to
// HALT with bus_err set.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   strt                     start request, looked at only in IDLE
//   opcode                   IR[15:12]
//   zero                     ALU zero flag (BEQ condition)
//   mem_ready                memory completes the current access this cycle
//   pc_wr .. pc_src          datapath controls (see the per-state decode)
//   halted, illegal, bus_err status flags (illegal/bus_err are sticky)
//   state                    current FSM state (debug/monitor)
//   instr_cnt                completed fetches, wraps
module mc_control_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             i_or_d,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [2:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'h0,
    S_FETCH    = 4'h1,
    S_DECODE   = 4'h2,
    S_EXEC_R   = 4'h3,
    S_EXEC_I   = 4'h4,
    S_MEM_ADDR = 4'h5,
    S_MEM_RD   = 4'h6,
    S_MEM_WB   = 4'h7,
    S_MEM_WR   = 4'h8,
    S_ALU_WB   = 4'h9,
    S_BRANCH   = 4'hA,
    S_JUMP     = 4'hB,
    S_HALT     = 4'hF
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait, timeout;
  logic              set_illegal, set_bus_err, fetch_done;
  logic              pc_wr_raw, ir_wr_raw, mem_rd_raw, mem_wr_raw, reg_wr_raw;
  logic              is_rtype;

  assign is_rtype = (opcode[3:2] == 2'b00);
  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                    (state_q == S_MEM_WR);
  // Last allowed wait cycle: a ready on this cycle still completes normally.
  assign timeout  = mem_wait && !mem_ready &&
                    (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    pc_wr_raw   = 1'b0;
    ir_wr_raw   = 1'b0;
    mem_rd_raw  = 1'b0;
    mem_wr_raw  = 1'b0;
    reg_wr_raw  = 1'b0;
    i_or_d      = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 3'b000;
    alu_op      = 2'b00;
    pc_src      = 2'b00;
    halted      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    fetch_done  = 1'b0;
    case (state_q)
      S_IDLE: if (strt) state_d = S_FETCH;
      S_FETCH: begin
        mem_rd_raw = 1'b1;
        alu_src_b  = 3'b001;
        if (mem_ready) begin
          ir_wr_raw  = 1'b1;
          pc_wr_raw  = 1'b1;
          fetch_done = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_DECODE: begin
        // Speculative branch target goes into ALUout here.
        alu_src_b = 3'b011;
        case (opcode)
          4'b0000, 4'b0001, 4'b0010, 4'b0011: state_d = S_EXEC_R;
          4'b0100:          state_d = S_EXEC_I;
          4'b0101, 4'b0110: state_d = S_MEM_ADDR;
          4'b0111:          state_d = S_BRANCH;
          4'b1000:          state_d = S_JUMP;
          4'b1111:          state_d = S_HALT;
          default: begin
            set_illegal = 1'b1;
            state_d     = S_HALT;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = opcode[1:0];
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'b010;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_wr_raw = 1'b1;
        reg_dst    = is_rtype;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'b010;
        state_d   = (opcode == 4'b0110) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_rd_raw = 1'b1;
        i_or_d     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_MEM_WB: begin
        reg_wr_raw = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr_raw = 1'b1;
        i_or_d     = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout) begin
          set_bus_err = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_wr_raw = zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src    = 2'b10;
        pc_wr_raw = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // Write strobes are killed during reset so an in-flight access cannot
  // commit anything on the reset edge.
  assign pc_wr  = pc_wr_raw  & ~rst;
  assign ir_wr  = ir_wr_raw  & ~rst;
  assign mem_rd = mem_rd_raw & ~rst;
  assign mem_wr = mem_wr_raw & ~rst;
  assign reg_wr = reg_wr_raw & ~rst;
  assign state  = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_cnt  <= '0;
      instr_cnt <= '0;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) wait_cnt <= '0;
      else if (mem_wait)      wait_cnt <= wait_cnt + WAIT_W'(1);
      else                    wait_cnt <= '0;
      if (fetch_done)  instr_cnt <= instr_cnt + CNT_W'(1);
      if (set_illegal) illegal   <= 1'b1;
      if (set_bus_err) bus_err   <= 1'b1;
    end
  end

endmodule
